fa_bist: RTL and testbench



---
 rtl/fa_bist_pkg.sv | 21 ++
 rtl/fa_bist_if.sv | 11 +
 rtl/fa_bist.sv | 128 ++++++++++++
 tb/tb_fa_bist.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fa_bist_pkg.sv
// Shared types, sizes and golden model for the full-adder BIST controller.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned ERR_W       = 4;

  // Reference response of a 1-bit full adder, packed as {cout, s}.
  function automatic logic [1:0] fa_expect(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/fa_bist_if.sv
// Connection between the BIST controller and the external full adder under test.
interface fa_bist_if;
  logic a;
  logic b;
  logic cin;
  logic s;
  logic cout;

  modport master (output a, output b, output cin, input s, input cout);
  modport slave  (input a, input b, input cin, output s, output cout);
endinterface

// File: rtl/fa_bist.sv
// BIST controller: walks all 8 full-adder input vectors, checks each response
// against the golden model and reports pass, error count and first failing vector.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  fa_bist_if.master        fa,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail
);

  state_t             r_state, w_state;
  logic [VEC_W-1:0]   r_v, w_v;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [ERR_W-1:0]   r_err, w_err;
  logic [VEC_W-1:0]   r_ff, w_ff;
  logic [VEC_W-1:0]   r_abc, w_abc;
  logic               r_pass, w_pass;
  logic               r_done, w_done;
  logic               r_busy, w_busy;
  logic [1:0]         w_exp;
  logic               w_mismatch;

  // Response is compared against the vector index, which equals the driven operands.
  assign w_exp      = fa_expect(r_v[2], r_v[1], r_v[0]);
  assign w_mismatch = (w_exp != {fa.cout, fa.s});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_v     <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_ff    <= '0;
      r_abc   <= '0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_v     <= w_v;
      r_cnt   <= w_cnt;
      r_err   <= w_err;
      r_ff    <= w_ff;
      r_abc   <= w_abc;
      r_pass  <= w_pass;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_v     = r_v;
    w_cnt   = r_cnt;
    w_err   = r_err;
    w_ff    = r_ff;
    w_pass  = r_pass;
    w_done  = 1'b0;
    w_busy  = r_busy;
    w_abc   = '0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state = DRIVE;
          w_v     = '0;
          w_cnt   = '0;
          w_err   = '0;
          w_ff    = '0;
          w_pass  = 1'b0;
          w_busy  = 1'b1;
        end
      end
      DRIVE: begin
        if (r_cnt == CNT_W'(SETTLE - 1)) begin
          w_state = CHECK;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (w_mismatch) begin
          w_err = r_err + ERR_W'(1);
          if (r_err == '0) w_ff = r_v;
        end
        // Pass uses the final count, including a mismatch on the last vector.
        if (r_v == VEC_W'(NUM_VECTORS - 1)) begin
          w_state = DONE;
          w_v     = '0;
          w_done  = 1'b1;
          w_pass  = (w_err == '0);
        end else begin
          w_state = DRIVE;
          w_v     = r_v + VEC_W'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase

    if ((w_state == DRIVE) || (w_state == CHECK)) w_abc = w_v;
  end

  assign fa.a       = r_abc[2];
  assign fa.b       = r_abc[1];
  assign fa.cin     = r_abc[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign first_fail = r_ff;

endmodule

// File: tb/tb_fa_bist.sv
// Directed bench for fa_bist: two controllers (settle 1 and 3) each driving a
// behavioural full adder with selectable faults; run results go through a scoreboard.
module tb_fa_bist;

  typedef struct packed {
    logic       pass;
    logic [3:0] err;
    logic [2:0] ff;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] mode1 = 2'd0;
  logic [1:0] mode3 = 2'd0;

  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [3:0] err1, err3;
  logic [2:0] ff1, ff3;

  int checks   = 0;
  int failures = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  fa_bist_if if1();
  fa_bist_if if3();

  // Adder under test; mode 1 = cout stuck at 0, mode 2 = sum inverted.
  assign if1.s    = (if1.a ^ if1.b ^ if1.cin) ^ (mode1 == 2'd2);
  assign if1.cout = (mode1 == 2'd1) ? 1'b0 : ((if1.a & if1.b) | (if1.a & if1.cin) | (if1.b & if1.cin));
  assign if3.s    = (if3.a ^ if3.b ^ if3.cin) ^ (mode3 == 2'd2);
  assign if3.cout = (mode3 == 2'd1) ? 1'b0 : ((if3.a & if3.b) | (if3.a & if3.cin) | (if3.b & if3.cin));

  fa_bist #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .fa(if1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_fail(ff1)
  );

  fa_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .fa(if3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_fail(ff3)
  );

  // {busy, done, pass, err[3:0], ff[2:0], abc[2:0]}
  function automatic logic [12:0] snap(input int sel);
    if (sel == 0) return {busy1, done1, pass1, err1, ff1, if1.a, if1.b, if1.cin};
    return {busy3, done3, pass3, err3, ff3, if3.a, if3.b, if3.cin};
  endfunction

  function automatic logic [1:0] adder_resp(input logic [1:0] mode, input logic [2:0] v);
    logic x, y, c, sm, co;
    x  = v[2];
    y  = v[1];
    c  = v[0];
    sm = x ^ y ^ c;
    co = (x & y) | (x & c) | (y & c);
    if (mode == 2'd1) co = 1'b0;
    if (mode == 2'd2) sm = ~sm;
    return {co, sm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int sel, input int settle, input bit hold, input string tag);
    res_t       e;
    logic [1:0] m;
    logic [12:0] o;
    logic [2:0] vv;
    m = (sel == 0) ? mode1 : mode3;
    e = '0;
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      if (adder_resp(m, vv) != adder_resp(2'd0, vv)) begin
        if (e.err == 4'd0) e.ff = vv;
        e.err = e.err + 4'd1;
      end
    end
    e.pass = (e.err == 4'd0);
    if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) begin
      if (sel == 0) start1 = 1'b0; else start3 = 1'b0;
    end
    o = snap(sel);
    chk({tag, " cleared"}, 32'(o[10:3]), 32'h0);
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k <= settle; k++) begin
        o = snap(sel);
        chk({tag, " vec"}, 32'({o[12], o[11], o[2:0]}), 32'({1'b1, 1'b0, 3'(v)}));
        @(posedge clk); #1;
      end
    end
    o = snap(sel);
    chk({tag, " done"}, 32'({o[12], o[11], o[2:0]}), 32'({1'b1, 1'b1, 3'd0}));
    e = sb_q.pop_front();
    chk({tag, " result"}, 32'(o[10:3]), 32'(e));
    @(posedge clk); #1;
    o = snap(sel);
    chk({tag, " idle"}, 32'({o[12], o[11], o[2:0]}), 32'h0);
    chk({tag, " held"}, 32'(o[10:3]), 32'(e));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset dut1", 32'(snap(0)), 32'h0);
    chk("reset dut3", 32'(snap(1)), 32'h0);

    mode1 = 2'd0;
    run(0, 1, 1'b0, "good_s1");
    mode1 = 2'd1;
    run(0, 1, 1'b0, "cout_stuck0");
    mode1 = 2'd2;
    run(0, 1, 1'b0, "s_inverted");

    // start held across two back-to-back runs, second one with a good adder
    mode1 = 2'd1;
    run(0, 1, 1'b1, "hold_run1");
    mode1 = 2'd0;
    run(0, 1, 1'b1, "hold_run2");
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("hold_release busy", 32'(busy1), 32'h0);

    // reset while checking vector 4 of a faulty run
    mode1 = 2'd1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst vec4", 32'(snap(0) & 13'h0007), 32'h4);
    chk("pre_rst err", 32'(err1), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst dut1", 32'(snap(0)), 32'h0);
    chk("mid_rst dut3", 32'(snap(1)), 32'h0);
    mode1 = 2'd0;
    run(0, 1, 1'b0, "post_rst");

    mode3 = 2'd0;
    run(1, 3, 1'b0, "good_s3");
    mode3 = 2'd1;
    run(1, 3, 1'b0, "s3_cout_stuck0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
